alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor of the team's combinational ALU. Takes operand pairs plus a 6-bit function code through a valid/ready handshake, registers them, computes the result and status flags, and presents them on a registered output with backpressure support. It sits between the operand-fetch and writeback stages of the datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_core.sv | 91 +++++++++
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the pipelined ALU: function codes and
//                the status-flag bundle carried from compute to output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int C_NB_OP_CODE = 6;

    localparam logic [C_NB_OP_CODE-1:0] OP_SLL  = 6'd0;
    localparam logic [C_NB_OP_CODE-1:0] OP_SRA  = 6'd3;
    localparam logic [C_NB_OP_CODE-1:0] OP_SRL  = 6'd4;
    localparam logic [C_NB_OP_CODE-1:0] OP_ADD  = 6'd32;
    localparam logic [C_NB_OP_CODE-1:0] OP_SUB  = 6'd34;
    localparam logic [C_NB_OP_CODE-1:0] OP_AND  = 6'd36;
    localparam logic [C_NB_OP_CODE-1:0] OP_OR   = 6'd37;
    localparam logic [C_NB_OP_CODE-1:0] OP_XOR  = 6'd38;
    localparam logic [C_NB_OP_CODE-1:0] OP_NOR  = 6'd39;
    localparam logic [C_NB_OP_CODE-1:0] OP_SLT  = 6'd42;
    localparam logic [C_NB_OP_CODE-1:0] OP_SLTU = 6'd43;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU datapath: result, status flags and
//                illegal-code decode.
//  Ports       : i_data_a    - signed operand A
//                i_data_b    - signed operand B / unsigned shift amount
//                i_operation - function code
//                o_result    - result
//                o_flags     - zero / negative / carry / overflow
//                o_illegal   - function code not recognised
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation,
    output logic [NB_DATA-1:0] o_result,
    output alu_flags_t         o_flags,
    output logic               o_illegal
);

    localparam int                 NB_SHAMT      = $clog2(NB_DATA);
    localparam logic [NB_DATA-1:0] C_SHIFT_LIMIT = NB_DATA'(NB_DATA);

    logic [NB_DATA:0]    w_sum;
    logic [NB_DATA:0]    w_diff;
    logic [NB_SHAMT-1:0] w_shamt;
    logic                w_shift_big;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [NB_DATA-1:0]  w_result;
    logic                w_carry;
    logic                w_overflow;
    logic                w_illegal;

    // One extra bit so the carry/borrow falls out of the MSB.
    assign w_sum       = {1'b0, i_data_a} + {1'b0, i_data_b};
    assign w_diff      = {1'b0, i_data_a} - {1'b0, i_data_b};
    assign w_shamt     = i_data_b[NB_SHAMT-1:0];
    // The whole B value counts, so large amounts saturate instead of wrapping.
    assign w_shift_big = (i_data_b >= C_SHIFT_LIMIT);
    assign w_sign_a    = i_data_a[NB_DATA-1];
    assign w_sign_b    = i_data_b[NB_DATA-1];

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_illegal  = 1'b0;
        case (i_operation)
            NB_OP'(OP_SLL): w_result = w_shift_big ? '0 : (i_data_a << w_shamt);
            NB_OP'(OP_SRL): w_result = w_shift_big ? '0 : (i_data_a >> w_shamt);
            NB_OP'(OP_SRA): w_result = w_shift_big ? {NB_DATA{w_sign_a}}
                                                   : NB_DATA'($signed(i_data_a) >>> w_shamt);
            NB_OP'(OP_ADD): begin
                w_result   = w_sum[NB_DATA-1:0];
                w_carry    = w_sum[NB_DATA];
                w_overflow = (w_sign_a == w_sign_b) && (w_sum[NB_DATA-1] != w_sign_a);
            end
            NB_OP'(OP_SUB): begin
                w_result   = w_diff[NB_DATA-1:0];
                // Wrap-around of the widened difference is the unsigned borrow.
                w_carry    = w_diff[NB_DATA];
                w_overflow = (w_sign_a != w_sign_b) && (w_diff[NB_DATA-1] != w_sign_a);
            end
            NB_OP'(OP_AND): w_result = i_data_a & i_data_b;
            NB_OP'(OP_OR):  w_result = i_data_a | i_data_b;
            NB_OP'(OP_XOR): w_result = i_data_a ^ i_data_b;
            NB_OP'(OP_NOR): w_result = ~(i_data_a | i_data_b);
            NB_OP'(OP_SLT): w_result = {{(NB_DATA-1){1'b0}},
                                        ($signed(i_data_a) < $signed(i_data_b))};
            NB_OP'(OP_SLTU): w_result = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            default:        w_illegal = 1'b1;
        endcase
    end

    assign o_result          = w_result;
    assign o_illegal         = w_illegal;
    assign o_flags.zero      = (w_result == '0);
    assign o_flags.negative  = w_result[NB_DATA-1];
    assign o_flags.carry     = w_carry;
    assign o_flags.overflow  = w_overflow;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshake on both
//                sides. S1 holds the accepted request, S2 the computed result.
//  Ports       : i_clk, i_reset                - clock, sync active-high reset
//                i_valid, o_ready              - request handshake
//                i_data_a, i_data_b, i_operation - request payload
//                o_valid, i_ready              - result handshake
//                o_result, o_zero, o_negative, o_carry, o_overflow, o_illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_negative,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_illegal
);

    // Stage 1 state
    logic               s1_valid_q,  s1_valid_d;
    logic [NB_DATA-1:0] s1_a_q,      s1_a_d;
    logic [NB_DATA-1:0] s1_b_q,      s1_b_d;
    logic [NB_OP-1:0]   s1_op_q,     s1_op_d;

    // Stage 2 state
    logic               s2_valid_q,  s2_valid_d;
    logic [NB_DATA-1:0] s2_result_q, s2_result_d;
    alu_flags_t         s2_flags_q,  s2_flags_d;
    logic               s2_illegal_q, s2_illegal_d;

    logic               w_s1_load;
    logic               w_s2_load;
    logic [NB_DATA-1:0] w_core_result;
    alu_flags_t         w_core_flags;
    logic               w_core_illegal;

    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu_core (
        .i_data_a    (s1_a_q),
        .i_data_b    (s1_b_q),
        .i_operation (s1_op_q),
        .o_result    (w_core_result),
        .o_flags     (w_core_flags),
        .o_illegal   (w_core_illegal)
    );

    // Readiness depends only on registered state and i_ready, never i_valid.
    assign w_s2_load = !s2_valid_q || i_ready;
    assign w_s1_load = !s1_valid_q || w_s2_load;
    assign o_ready   = w_s1_load;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_flags_d   = s2_flags_q;
        s2_illegal_d = s2_illegal_q;

        if (w_s1_load) begin
            s1_valid_d = i_valid;
            // Payload only captured on a real accept; stale data is harmless.
            if (i_valid) begin
                s1_a_d  = i_data_a;
                s1_b_d  = i_data_b;
                s1_op_d = i_operation;
            end
        end

        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d  = w_core_result;
                s2_flags_d   = w_core_flags;
                s2_illegal_d = w_core_illegal;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_flags_q   <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_flags_q   <= s2_flags_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign o_valid    = s2_valid_q;
    assign o_result   = s2_result_q;
    assign o_zero     = s2_flags_q.zero;
    assign o_negative = s2_flags_q.negative;
    assign o_carry    = s2_flags_q.carry;
    assign o_overflow = s2_flags_q.overflow;
    assign o_illegal  = s2_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking scoreboard bench for alu_pipe (NB_DATA=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
        logic       ill;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_data_a = '0;
    logic [7:0] i_data_b = '0;
    logic [5:0] i_operation = '0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_result;
    logic       o_zero, o_negative, o_carry, o_overflow, o_illegal;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    int   inflight = 0;
    logic hold = 1'b0;
    logic [12:0] held;
    logic saw_not_ready = 1'b0;
    logic rnd_done = 1'b0;

    alu_pipe #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_a    (i_data_a),
        .i_data_b    (i_data_b),
        .i_operation (i_operation),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_zero      (o_zero),
        .o_negative  (o_negative),
        .o_carry     (o_carry),
        .o_overflow  (o_overflow),
        .o_illegal   (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model written with plain integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int sa = (a > 127) ? a - 256 : a;
        int sb = (b > 127) ? b - 256 : b;
        int r = 0;
        e = '0;
        case (op)
            32: begin r = a + b; e.c = (r > 255); e.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            34: begin r = a - b; e.c = (a < b);   e.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = ~(a | b);
            42: r = (sa < sb) ? 1 : 0;
            43: r = (a < b) ? 1 : 0;
            0:  r = (b >= 8) ? 0 : (a << b);
            4:  r = (b >= 8) ? 0 : (a >> b);
            3:  r = (b >= 8) ? ((a > 127) ? 255 : 0) : (sa >>> b);
            default: e.ill = 1'b1;
        endcase
        r     = r & 255;
        e.res = r[7:0];
        e.z   = (r == 0);
        e.n   = (r > 127);
        return e;
    endfunction

    // Inputs change only just after posedge, so values seen here are the ones
    // the next rising edge acts on.
    always @(negedge i_clk) begin
        if (i_reset) begin
            sb_q.delete();
            inflight = 0;
            hold = 1'b0;
        end else begin
            check("o_ready", {31'd0, o_ready}, {31'd0, (inflight < 2) || i_ready});
            if (!o_ready) saw_not_ready = 1'b1;
            if (hold) begin
                check("stall_stable", {19'd0, o_valid, o_result, o_zero, o_negative,
                                       o_carry, o_overflow, o_illegal}, {19'd0, 1'b1, held});
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", {31'd0, o_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result",   {24'd0, o_result},   {24'd0, e.res});
                    check("zero",     {31'd0, o_zero},     {31'd0, e.z});
                    check("negative", {31'd0, o_negative}, {31'd0, e.n});
                    check("carry",    {31'd0, o_carry},    {31'd0, e.c});
                    check("overflow", {31'd0, o_overflow}, {31'd0, e.v});
                    check("illegal",  {31'd0, o_illegal},  {31'd0, e.ill});
                    inflight--;
                end
            end
            if (i_valid && o_ready) begin
                sb_q.push_back(model(int'(i_operation), int'(i_data_a), int'(i_data_b)));
                inflight++;
            end
            hold = o_valid && !i_ready;
            held = {o_result, o_zero, o_negative, o_carry, o_overflow, o_illegal};
        end
    end

    task automatic send(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        int   n = 0;
        logic acc = 1'b0;
        i_valid = 1'b1; i_operation = op; i_data_a = a; i_data_b = b;
        do begin
            @(negedge i_clk); acc = o_ready;
            @(posedge i_clk); #1; n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
        i_valid = 1'b0;
        i_operation = 6'h2A ^ op; i_data_a = ~a; i_data_b = ~b;  // junk, must be ignored
    endtask

    // Single request from idle: checks latency and a hand-computed result.
    task automatic run_one(input string tag, input logic [5:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res);
        send(op, a, b);
        check({tag, "_lat0"}, {31'd0, o_valid}, 32'd0);
        @(posedge i_clk); #1;
        check({tag, "_lat1"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_res"}, {24'd0, o_result}, {24'd0, exp_res});
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        check("rst_valid",  {31'd0, o_valid}, 32'd0);
        check("rst_ready",  {31'd0, o_ready}, 32'd1);
        check("rst_result", {24'd0, o_result}, 32'd0);
        check("rst_flags",  {27'd0, o_zero, o_negative, o_carry, o_overflow, o_illegal}, 32'd0);

        run_one("add_ovf",  6'd32, 8'h7F, 8'h01, 8'h80);
        run_one("sub_brw",  6'd34, 8'h00, 8'h01, 8'hFF);
        run_one("sub_ovf",  6'd34, 8'h80, 8'h01, 8'h7F);
        run_one("sra_big",  6'd3,  8'h80, 8'd9,  8'hFF);
        run_one("srl_big",  6'd4,  8'h80, 8'd9,  8'h00);
        run_one("sll7",     6'd0,  8'h01, 8'd7,  8'h80);
        run_one("slt",      6'd42, 8'hFF, 8'h01, 8'h01);
        run_one("sltu",     6'd43, 8'hFF, 8'h01, 8'h00);
        run_one("illegal",  6'd50, 8'h12, 8'h00, 8'h00);
        run_one("and",      6'd36, 8'hA5, 8'h3C, 8'h24);
        run_one("or",       6'd37, 8'hA5, 8'h3C, 8'hBD);
        run_one("xor",      6'd38, 8'hA5, 8'h3C, 8'h99);
        run_one("nor",      6'd39, 8'hA5, 8'h3C, 8'h42);
        run_one("add_cz",   6'd32, 8'hFF, 8'h01, 8'h00);
        run_one("sra3",     6'd3,  8'h90, 8'd3,  8'hF2);
        run_one("sra8",     6'd3,  8'h40, 8'd8,  8'h00);

        // Back-to-back stream with a three-cycle consumer stall.
        saw_not_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(6'd32, 8'(8'h10 * i + 3), 8'(i + 1));
            end
            begin
                repeat (2) @(posedge i_clk);
                #1 i_ready = 1'b0;
                repeat (3) @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        repeat (4) @(posedge i_clk);
        #1;
        check("stream_backpressure", {31'd0, saw_not_ready}, 32'd1);
        check("stream_drained", sb_q.size(), 32'd0);

        // Reset with two requests in flight.
        i_ready = 1'b0;
        send(6'd32, 8'h01, 8'h02);
        send(6'd34, 8'h09, 8'h04);
        check("pre_rst_inflight", inflight, 32'd2);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("post_rst_valid", {31'd0, o_valid}, 32'd0);
        check("post_rst_ready", {31'd0, o_ready}, 32'd1);
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            check("no_stale", {31'd0, o_valid}, 32'd0);
        end

        // Random traffic with random backpressure.
        fork
            begin
                int ops[12] = '{0, 3, 4, 32, 34, 36, 37, 38, 39, 42, 43, 50};
                for (int i = 0; i < 40; i++) begin
                    int k = $urandom_range(11);
                    logic [7:0] bb;
                    bb = (ops[k] < 5) ? 8'($urandom_range(12)) : 8'($urandom);
                    send(6'(ops[k]), 8'($urandom), bb);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge i_clk); #1;
                    i_ready = ($urandom_range(3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge i_clk);
        #1;
        check("final_drain", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
